cpu_control_fsm: RTL and testbench

//  Multi-cycle LEGv8 control sequencer. Decodes the 11-bit opcode field
//  (inst[31:21]) once per instruction and steps FETCH/DECODE/EXEC/MEM/WB,

---
 rtl/cpu_control_fsm.sv | 213 +++++++++++++++++++++
 tb/tb_cpu_control_fsm.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_control_fsm.sv
// Multi-cycle LEGv8 control sequencer.
// Steps FETCH -> DECODE -> EXEC -> (MEM) -> (WB) once per instruction, with a
// data-memory wait handshake and timeout, sticky HALT/FAULT states and a
// retired-instruction counter. Control outputs are decoded from the current
// state and the opcode class captured in FETCH; the few that must react in
// the same cycle (ir_load, branch pc_src, STUR retire) also look at the
// qualifying input.
module cpu_control_fsm #(
   parameter int MEM_TIMEOUT = 8,
   parameter int CNT_W       = 4,
   parameter int RETIRE_W    = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [10:0]         inst31_21,
   input  logic                inst_valid,
   input  logic                mem_ready,
   input  logic                zero,
   output logic                ir_load,
   output logic                pc_write,
   output logic [1:0]          pc_src,
   output logic                Reg2Loc,
   output logic [1:0]          ALUOp,
   output logic [1:0]          ALUSrc,
   output logic                MemRead,
   output logic                MemWrite,
   output logic                MemtoReg,
   output logic                RegWrite,
   output logic                halted,
   output logic                illegal_op,
   output logic                mem_fault,
   output logic [2:0]          state,
   output logic [RETIRE_W-1:0] instr_count
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd5,
      S_FAULT  = 3'd6
   } state_t;

   typedef enum logic [3:0] {
      C_ILLEGAL = 4'd0,
      C_LDUR    = 4'd1,
      C_STUR    = 4'd2,
      C_RTYPE   = 4'd3,
      C_ADDI    = 4'd4,
      C_CBZ     = 4'd5,
      C_CBNZ    = 4'd6,
      C_B       = 4'd7,
      C_HALT    = 4'd8
   } op_class_t;

   localparam logic [CNT_W-1:0] LP_WAIT_LAST = CNT_W'(MEM_TIMEOUT - 1);

   state_t              r_state;
   op_class_t           r_class;
   op_class_t           w_class;
   logic [CNT_W-1:0]    r_wait;
   logic                r_illegal;
   logic                r_mem_fault;
   logic [RETIRE_W-1:0] r_count;
   logic                w_is_branch;

   // Classify the incoming opcode field; only consumed in FETCH.
   always_comb begin
      casez (inst31_21)
         11'b11111000010: w_class = C_LDUR;
         11'b11111000000: w_class = C_STUR;
         11'b10001011000,
         11'b11001011000,
         11'b10001010000,
         11'b10101010000: w_class = C_RTYPE;
         11'b1001000100?: w_class = C_ADDI;
         11'b10110100???: w_class = C_CBZ;
         11'b10110101???: w_class = C_CBNZ;
         11'b000101?????: w_class = C_B;
         11'b11111111111: w_class = C_HALT;
         default:         w_class = C_ILLEGAL;
      endcase
   end

   assign w_is_branch = (r_class == C_B) || (r_class == C_CBZ) || (r_class == C_CBNZ);

   // Sequencer: state, latched class, MEM wait counter, sticky flags, retire count.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= S_FETCH;
         r_class     <= C_ILLEGAL;
         r_wait      <= '0;
         r_illegal   <= 1'b0;
         r_mem_fault <= 1'b0;
         r_count     <= '0;
      end else begin
         // NOTE: non-blocking assignments keep every register here reading the
         // pre-edge values, so statement order inside this block cannot matter.
         if (pc_write) r_count <= r_count + 1'b1;

         case (r_state)
            S_FETCH: begin
               if (inst_valid) begin
                  r_class <= w_class;
                  r_state <= S_DECODE;
               end
            end
            S_DECODE: begin
               if (r_class == C_ILLEGAL) begin
                  r_illegal <= 1'b1;
                  r_state   <= S_FAULT;
               end else if (r_class == C_HALT) begin
                  r_state <= S_HALT;
               end else begin
                  r_state <= S_EXEC;
               end
            end
            S_EXEC: begin
               if (w_is_branch) begin
                  r_state <= S_FETCH;
               end else if ((r_class == C_LDUR) || (r_class == C_STUR)) begin
                  r_wait  <= '0;
                  r_state <= S_MEM;
               end else begin
                  r_state <= S_WB;
               end
            end
            S_MEM: begin
               // A ready in the final allowed cycle still completes the access.
               if (mem_ready) begin
                  r_state <= (r_class == C_LDUR) ? S_WB : S_FETCH;
               end else if (r_wait == LP_WAIT_LAST) begin
                  r_mem_fault <= 1'b1;
                  r_state     <= S_FAULT;
               end else begin
                  r_wait <= r_wait + 1'b1;
               end
            end
            S_WB:    r_state <= S_FETCH;
            S_HALT:  r_state <= S_HALT;
            S_FAULT: r_state <= S_FAULT;
            default: r_state <= S_FETCH;
         endcase
      end
   end

   // Datapath controls decoded from state and the latched opcode class.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves one
      // unassigned, which would otherwise infer a latch.
      ir_load  = 1'b0;
      pc_write = 1'b0;
      pc_src   = 2'b00;
      Reg2Loc  = 1'b0;
      ALUOp    = 2'b00;
      ALUSrc   = 2'b00;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      MemtoReg = 1'b0;
      RegWrite = 1'b0;
      halted   = 1'b0;

      if ((r_state == S_DECODE) || (r_state == S_EXEC) ||
          (r_state == S_MEM) || (r_state == S_WB)) begin
         case (r_class)
            C_LDUR:  begin Reg2Loc = 1'b0; ALUOp = 2'b00; ALUSrc = 2'b01; end
            C_STUR:  begin Reg2Loc = 1'b1; ALUOp = 2'b00; ALUSrc = 2'b01; end
            C_RTYPE: begin Reg2Loc = 1'b0; ALUOp = 2'b10; ALUSrc = 2'b00; end
            C_ADDI:  begin Reg2Loc = 1'b0; ALUOp = 2'b10; ALUSrc = 2'b10; end
            C_CBZ,
            C_CBNZ:  begin Reg2Loc = 1'b1; ALUOp = 2'b01; ALUSrc = 2'b00; end
            default: begin Reg2Loc = 1'b0; ALUOp = 2'b00; ALUSrc = 2'b00; end
         endcase
      end

      case (r_state)
         S_FETCH: ir_load = inst_valid;
         S_EXEC: begin
            if (r_class == C_B) begin
               pc_write = 1'b1;
               pc_src   = 2'b10;
            end else if (r_class == C_CBZ) begin
               pc_write = 1'b1;
               pc_src   = zero ? 2'b01 : 2'b00;
            end else if (r_class == C_CBNZ) begin
               pc_write = 1'b1;
               pc_src   = zero ? 2'b00 : 2'b01;
            end
         end
         S_MEM: begin
            MemRead  = (r_class == C_LDUR);
            MemWrite = (r_class == C_STUR);
            pc_write = (r_class == C_STUR) && mem_ready;
         end
         S_WB: begin
            RegWrite = 1'b1;
            MemtoReg = (r_class == C_LDUR);
            pc_write = 1'b1;
         end
         S_HALT,
         S_FAULT: halted = 1'b1;
         default: ;
      endcase
   end

   assign state       = r_state;
   assign illegal_op  = r_illegal;
   assign mem_fault   = r_mem_fault;
   assign instr_count = r_count;

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Self-checking bench for cpu_control_fsm. Each instruction is expanded by a
// small reference model into its expected per-cycle control trace (from the
// per-class latencies and control table) and compared cycle by cycle. A second
// instance with a 4-bit retire counter shares all inputs to exercise wrap.
module tb_cpu_control_fsm;

   localparam int MEM_TIMEOUT = 8;

   typedef enum int {K_LDUR, K_STUR, K_R, K_ADDI, K_CBZ, K_CBNZ, K_B, K_HALT, K_ILL} kind_t;

   typedef struct packed {
      logic [2:0] st;
      logic       ir_load;
      logic       pc_write;
      logic [1:0] pc_src;
      logic       reg2loc;
      logic [1:0] aluop;
      logic [1:0] alusrc;
      logic       memread;
      logic       memwrite;
      logic       memtoreg;
      logic       regwrite;
      logic       halted;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [10:0] inst31_21;
   logic        inst_valid, mem_ready, zero;

   logic        ir_load, pc_write, Reg2Loc, MemRead, MemWrite, MemtoReg, RegWrite;
   logic        halted, illegal_op, mem_fault;
   logic [1:0]  pc_src, ALUOp, ALUSrc;
   logic [2:0]  state;
   logic [15:0] instr_count;

   logic        c4_ir_load, c4_pc_write, c4_Reg2Loc, c4_MemRead, c4_MemWrite, c4_MemtoReg;
   logic        c4_RegWrite, c4_halted, c4_illegal_op, c4_mem_fault;
   logic [1:0]  c4_pc_src, c4_ALUOp, c4_ALUSrc;
   logic [2:0]  c4_state;
   logic [3:0]  c4_count;

   int vectors = 0;
   int miscompares = 0;
   int exp_count = 0;

   always #5 clk = ~clk;

   cpu_control_fsm #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(4), .RETIRE_W(16)) u_dut (
      .clk(clk), .reset(reset), .inst31_21(inst31_21), .inst_valid(inst_valid),
      .mem_ready(mem_ready), .zero(zero), .ir_load(ir_load), .pc_write(pc_write),
      .pc_src(pc_src), .Reg2Loc(Reg2Loc), .ALUOp(ALUOp), .ALUSrc(ALUSrc),
      .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
      .halted(halted), .illegal_op(illegal_op), .mem_fault(mem_fault), .state(state),
      .instr_count(instr_count)
   );

   cpu_control_fsm #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(4), .RETIRE_W(4)) u_dut_c4 (
      .clk(clk), .reset(reset), .inst31_21(inst31_21), .inst_valid(inst_valid),
      .mem_ready(mem_ready), .zero(zero), .ir_load(c4_ir_load), .pc_write(c4_pc_write),
      .pc_src(c4_pc_src), .Reg2Loc(c4_Reg2Loc), .ALUOp(c4_ALUOp), .ALUSrc(c4_ALUSrc),
      .MemRead(c4_MemRead), .MemWrite(c4_MemWrite), .MemtoReg(c4_MemtoReg),
      .RegWrite(c4_RegWrite), .halted(c4_halted), .illegal_op(c4_illegal_op),
      .mem_fault(c4_mem_fault), .state(c4_state), .instr_count(c4_count)
   );

   function automatic logic rnd1();
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic logic [10:0] rnd11();
      return 11'($urandom);
   endfunction

   // Opcode generator: fixed bits from the encoding table, random don't-cares.
   function automatic logic [10:0] make_op(input kind_t k);
      logic [10:0] r;
      r = rnd11();
      case (k)
         K_LDUR: return 11'b11111000010;
         K_STUR: return 11'b11111000000;
         K_R: begin
            case ($urandom_range(0, 3))
               0: return 11'b10001011000;
               1: return 11'b11001011000;
               2: return 11'b10001010000;
               default: return 11'b10101010000;
            endcase
         end
         K_ADDI: return {10'b1001000100, r[0]};
         K_CBZ:  return {8'b10110100, r[2:0]};
         K_CBNZ: return {8'b10110101, r[2:0]};
         K_B:    return {6'b000101, r[4:0]};
         K_HALT: return 11'b11111111111;
         default: begin
            case ($urandom_range(0, 2))
               0: return 11'b00000000000;
               1: return 11'b11111000001;
               default: return 11'b11111111110;
            endcase
         end
      endcase
   endfunction

   // Per-class ALU/operand selects held from DECODE to the end of the instruction.
   function automatic exp_t ctrl_of(input kind_t k);
      exp_t e;
      e = '0;
      case (k)
         K_LDUR: begin e.reg2loc = 1'b0; e.aluop = 2'b00; e.alusrc = 2'b01; end
         K_STUR: begin e.reg2loc = 1'b1; e.aluop = 2'b00; e.alusrc = 2'b01; end
         K_R:    begin e.reg2loc = 1'b0; e.aluop = 2'b10; e.alusrc = 2'b00; end
         K_ADDI: begin e.reg2loc = 1'b0; e.aluop = 2'b10; e.alusrc = 2'b10; end
         K_CBZ,
         K_CBNZ: begin e.reg2loc = 1'b1; e.aluop = 2'b01; e.alusrc = 2'b00; end
         default: ;
      endcase
      return e;
   endfunction

   // Drive one cycle of inputs (called at posedge+1), compare all controls at negedge.
   task automatic apply_cycle(input logic iv, input logic [10:0] op, input logic rdy,
                              input logic z, input exp_t e, input string name);
      logic [16:0] act;
      inst_valid = iv;
      inst31_21  = op;
      mem_ready  = rdy;
      zero       = z;
      @(negedge clk);
      act = {state, ir_load, pc_write, pc_src, Reg2Loc, ALUOp, ALUSrc,
             MemRead, MemWrite, MemtoReg, RegWrite, halted};
      vectors++;
      if (act !== e) begin
         miscompares++;
         $display("FAIL %s @%0t: got %h expected %h", name, $time, act, e);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      logic [16:0] act;
      inst_valid = 1'b0;
      reset = 1'b1;
      #1;
      act = {state, ir_load, pc_write, pc_src, Reg2Loc, ALUOp, ALUSrc,
             MemRead, MemWrite, MemtoReg, RegWrite, halted};
      vectors++;
      if ({act, illegal_op, mem_fault, instr_count, c4_count} !== '0) begin
         miscompares++;
         $display("FAIL reset_immediate: got ctrl=%h flags=%b count=%0d/%0d expected all 0",
                  act, {illegal_op, mem_fault}, instr_count, c4_count);
      end
      @(posedge clk);
      #1;
      vectors++;
      if ({state, pc_write, RegWrite, instr_count} !== '0) begin
         miscompares++;
         $display("FAIL reset_hold: got state=%0d pc_write=%b RegWrite=%b count=%0d expected 0",
                  state, pc_write, RegWrite, instr_count);
      end
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      exp_count = 0;
   endtask

   // One instruction through the reference model: expected trace built from the
   // class latencies; w = MEM wait cycles, to = memory never answers.
   task automatic run_instr(input kind_t k, input logic [10:0] op, input int w,
                            input logic z, input bit to);
      exp_t c, e;
      int   nr;
      vectors++;
      if (instr_count !== 16'(exp_count) || c4_count !== 4'(exp_count)) begin
         miscompares++;
         $display("FAIL instr_count: got %0d/%0d expected %0d/%0d",
                  instr_count, c4_count, 16'(exp_count), 4'(exp_count));
      end
      c = ctrl_of(k);
      e = '0;
      e.ir_load = 1'b1;
      apply_cycle(1'b1, op, rnd1(), rnd1(), e, "fetch");
      e = c; e.st = 3'd1;
      apply_cycle(rnd1(), rnd11(), rnd1(), rnd1(), e, "decode");

      if (k == K_ILL || k == K_HALT) begin
         for (int i = 0; i < 4; i++) begin
            e = '0; e.st = (k == K_ILL) ? 3'd6 : 3'd5; e.halted = 1'b1;
            apply_cycle(rnd1(), rnd11(), rnd1(), rnd1(), e, "absorb");
         end
         vectors++;
         if ({illegal_op, mem_fault} !== {k == K_ILL, 1'b0}) begin
            miscompares++;
            $display("FAIL sticky_flags: got %b expected %b", {illegal_op, mem_fault},
                     {k == K_ILL, 1'b0});
         end
         return;
      end

      e = c; e.st = 3'd2;
      if (k == K_B || k == K_CBZ || k == K_CBNZ) begin
         e.pc_write = 1'b1;
         if (k == K_B) e.pc_src = 2'b10;
         else e.pc_src = ((k == K_CBZ) == z) ? 2'b01 : 2'b00;
         apply_cycle(rnd1(), rnd11(), rnd1(), z, e, "exec_branch");
         exp_count++;
         return;
      end
      apply_cycle(rnd1(), rnd11(), rnd1(), z, e, "exec");

      if (k == K_R || k == K_ADDI) begin
         e = c; e.st = 3'd4; e.regwrite = 1'b1; e.pc_write = 1'b1;
         apply_cycle(rnd1(), rnd11(), rnd1(), rnd1(), e, "wb_alu");
         exp_count++;
         return;
      end

      nr = to ? MEM_TIMEOUT : w;
      for (int i = 0; i < nr; i++) begin
         e = c; e.st = 3'd3; e.memread = (k == K_LDUR); e.memwrite = (k == K_STUR);
         apply_cycle(rnd1(), rnd11(), 1'b0, rnd1(), e, "mem_wait");
      end
      if (to) begin
         for (int i = 0; i < 4; i++) begin
            e = '0; e.st = 3'd6; e.halted = 1'b1;
            apply_cycle(rnd1(), rnd11(), rnd1(), rnd1(), e, "timeout_fault");
         end
         vectors++;
         if ({illegal_op, mem_fault} !== 2'b01) begin
            miscompares++;
            $display("FAIL timeout_flags: got %b expected 01", {illegal_op, mem_fault});
         end
         return;
      end
      e = c; e.st = 3'd3; e.memread = (k == K_LDUR); e.memwrite = (k == K_STUR);
      e.pc_write = (k == K_STUR);
      apply_cycle(rnd1(), rnd11(), 1'b1, rnd1(), e, "mem_ready");
      if (k == K_STUR) begin
         exp_count++;
         return;
      end
      e = c; e.st = 3'd4; e.regwrite = 1'b1; e.memtoreg = 1'b1; e.pc_write = 1'b1;
      apply_cycle(rnd1(), rnd11(), rnd1(), rnd1(), e, "wb_load");
      exp_count++;
   endtask

   task automatic test_reset();
      do_reset();
   endtask

   task automatic test_add();
      do_reset();
      run_instr(K_R, 11'b10001011000, 0, 1'b0, 1'b0);
      vectors++;
      if (instr_count !== 16'd1) begin
         miscompares++;
         $display("FAIL add_retire_count: got %0d expected 1", instr_count);
      end
   endtask

   task automatic test_ldur_wait();
      do_reset();
      run_instr(K_LDUR, make_op(K_LDUR), 2, rnd1(), 1'b0);
   endtask

   task automatic test_stur_timeout();
      do_reset();
      run_instr(K_STUR, make_op(K_STUR), 0, 1'b0, 1'b1);
   endtask

   task automatic test_branches();
      do_reset();
      run_instr(K_CBZ, make_op(K_CBZ), 0, 1'b1, 1'b0);
      run_instr(K_CBNZ, make_op(K_CBNZ), 0, 1'b1, 1'b0);
      run_instr(K_CBZ, make_op(K_CBZ), 0, 1'b0, 1'b0);
      run_instr(K_CBNZ, make_op(K_CBNZ), 0, 1'b0, 1'b0);
      run_instr(K_B, make_op(K_B), 0, rnd1(), 1'b0);
   endtask

   task automatic test_illegal_halt();
      do_reset();
      run_instr(K_ILL, 11'b00000000000, 0, 1'b0, 1'b0);
      do_reset();
      run_instr(K_HALT, 11'b11111111111, 0, 1'b0, 1'b0);
   endtask

   task automatic test_reset_in_mem();
      exp_t c, e;
      do_reset();
      run_instr(K_ADDI, make_op(K_ADDI), 0, 1'b0, 1'b0);
      c = ctrl_of(K_LDUR);
      e = '0; e.ir_load = 1'b1;
      apply_cycle(1'b1, make_op(K_LDUR), 1'b0, 1'b0, e, "rst_mem_fetch");
      e = c; e.st = 3'd1;
      apply_cycle(1'b0, rnd11(), 1'b0, 1'b0, e, "rst_mem_decode");
      e = c; e.st = 3'd2;
      apply_cycle(1'b0, rnd11(), 1'b0, 1'b0, e, "rst_mem_exec");
      e = c; e.st = 3'd3; e.memread = 1'b1;
      apply_cycle(1'b0, rnd11(), 1'b0, 1'b0, e, "rst_mem_wait");
      mem_ready = 1'b1;
      do_reset();
   endtask

   task automatic test_back_to_back();
      kind_t k;
      exp_t  idle;
      do_reset();
      for (int n = 0; n < 300; n++) begin
         k = kind_t'($urandom_range(0, 6));
         for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
            idle = '0;
            apply_cycle(1'b0, rnd11(), rnd1(), rnd1(), idle, "idle_fetch");
         end
         if ((k == K_LDUR || k == K_STUR) && $urandom_range(0, 24) == 0) begin
            run_instr(k, make_op(k), 0, rnd1(), 1'b1);
            do_reset();
         end else begin
            run_instr(k, make_op(k), int'($urandom_range(0, 4)), rnd1(), 1'b0);
         end
      end
      vectors++;
      if (instr_count !== 16'(exp_count) || c4_count !== 4'(exp_count)) begin
         miscompares++;
         $display("FAIL final_count: got %0d/%0d expected %0d/%0d",
                  instr_count, c4_count, 16'(exp_count), 4'(exp_count));
      end
   endtask

   initial begin
      reset      = 1'b1;
      inst31_21  = '0;
      inst_valid = 1'b0;
      mem_ready  = 1'b0;
      zero       = 1'b0;
      @(posedge clk);
      #1;
      test_reset();
      test_add();
      test_ldur_wait();
      test_stur_timeout();
      test_branches();
      test_illegal_halt();
      test_reset_in_mem();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
